// File: rtl/johnson_decoder_monitor.sv
// Johnson (twisted-ring) code decoder and stream integrity monitor.
// Decodes N-bit codes to 0..2N-1, checks successor order, locks, and counts errors.
module johnson_decoder_monitor #(
    parameter int N          = 4,
    parameter int LOCK_CNT   = 3,
    parameter bit ALLOW_HOLD = 1'b1
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_sample_en,
    input  logic [N-1:0]                  i_j_in,
    input  logic                          i_clr_err,
    output logic [$clog2(2*N)-1:0]        o_idx,
    output logic                          o_idx_valid,
    output logic                          o_illegal,
    output logic                          o_seq_err,
    output logic                          o_wrap,
    output logic                          o_locked,
    output logic [7:0]                    o_err_cnt
);

    localparam int IW = $clog2(2*N);
    localparam logic [IW-1:0] LAST_IDX = IW'(2*N-1);

    typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

    state_t         r_state, w_state_nxt;
    logic           r_ref_valid, w_ref_valid_nxt;
    logic [IW-1:0]  r_ref, w_ref_nxt;
    logic [3:0]     r_good_cnt, w_good_nxt, w_good_inc;
    logic [IW-1:0]  r_idx, w_idx_nxt;
    logic           r_idx_valid, w_idx_valid_nxt;
    logic           r_illegal, w_illegal_nxt;
    logic           r_seq_err, w_seq_err_nxt;
    logic           r_wrap, w_wrap_nxt;
    logic [7:0]     r_err_cnt, w_err_cnt_nxt;
    logic           w_err_event;

    int             w_trans;
    int             w_ones;
    logic           w_legal;
    logic [IW-1:0]  w_dec;
    logic [IW-1:0]  w_expect;
    logic           w_succ;
    logic           w_hold;

    // A legal code has at most one adjacent-bit transition; 2N - ones covers the tail half.
    always_comb begin
        w_trans = 0;
        w_ones  = 0;
        for (int b = 0; b < N-1; b++) begin
            if (i_j_in[b] != i_j_in[b+1]) w_trans = w_trans + 1;
        end
        for (int b = 0; b < N; b++) begin
            if (i_j_in[b]) w_ones = w_ones + 1;
        end
        w_legal = (w_trans <= 1);
        w_dec   = i_j_in[0] ? IW'(2*N - w_ones) : IW'(w_ones);
    end

    assign w_expect   = (r_ref == LAST_IDX) ? '0 : r_ref + 1'b1;
    assign w_succ     = r_ref_valid && (w_dec == w_expect);
    assign w_hold     = r_ref_valid && (w_dec == r_ref);
    assign w_good_inc = r_good_cnt + 4'd1;

    always_comb begin
        w_state_nxt     = r_state;
        w_ref_valid_nxt = r_ref_valid;
        w_ref_nxt       = r_ref;
        w_good_nxt      = r_good_cnt;
        w_idx_nxt       = r_idx;
        w_idx_valid_nxt = 1'b0;
        w_illegal_nxt   = 1'b0;
        w_seq_err_nxt   = 1'b0;
        w_wrap_nxt      = 1'b0;
        w_err_event     = 1'b0;
        w_err_cnt_nxt   = r_err_cnt;

        if (i_sample_en) begin
            if (!w_legal) begin
                w_illegal_nxt   = 1'b1;
                w_err_event     = 1'b1;
                w_state_nxt     = ST_UNLOCKED;
                w_ref_valid_nxt = 1'b0;
                w_good_nxt      = '0;
            end else begin
                w_idx_nxt       = w_dec;
                w_ref_nxt       = w_dec;
                w_ref_valid_nxt = 1'b1;
                w_wrap_nxt      = w_succ && (r_ref == LAST_IDX);
                case (r_state)
                    ST_UNLOCKED: begin
                        w_idx_valid_nxt = 1'b1;
                        if (!r_ref_valid) begin
                            w_good_nxt = '0;
                        end else if (w_succ) begin
                            w_good_nxt = w_good_inc;
                            if (w_good_inc >= 4'(LOCK_CNT)) w_state_nxt = ST_LOCKED;
                        end else if (!(w_hold && ALLOW_HOLD)) begin
                            w_good_nxt = '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_succ || (w_hold && ALLOW_HOLD)) begin
                            w_idx_valid_nxt = 1'b1;
                        end else begin
                            w_seq_err_nxt = 1'b1;
                            w_err_event   = 1'b1;
                            w_state_nxt   = ST_UNLOCKED;
                            w_good_nxt    = '0;
                        end
                    end
                    default: w_state_nxt = ST_UNLOCKED;
                endcase
            end
        end

        // Clear wins over the old count but still records an error on the same edge.
        if (i_clr_err) begin
            w_err_cnt_nxt = w_err_event ? 8'd1 : 8'd0;
        end else if (w_err_event && (r_err_cnt != 8'hFF)) begin
            w_err_cnt_nxt = r_err_cnt + 8'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_UNLOCKED;
            r_ref_valid <= 1'b0;
            r_ref       <= '0;
            r_good_cnt  <= '0;
            r_idx       <= '0;
            r_idx_valid <= 1'b0;
            r_illegal   <= 1'b0;
            r_seq_err   <= 1'b0;
            r_wrap      <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ref_valid <= w_ref_valid_nxt;
            r_ref       <= w_ref_nxt;
            r_good_cnt  <= w_good_nxt;
            r_idx       <= w_idx_nxt;
            r_idx_valid <= w_idx_valid_nxt;
            r_illegal   <= w_illegal_nxt;
            r_seq_err   <= w_seq_err_nxt;
            r_wrap      <= w_wrap_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
        end
    end

    assign o_idx       = r_idx;
    assign o_idx_valid = r_idx_valid;
    assign o_illegal   = r_illegal;
    assign o_seq_err   = r_seq_err;
    assign o_wrap      = r_wrap;
    assign o_locked    = (r_state == ST_LOCKED);
    assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_johnson_decoder_monitor.sv
// Directed bench for johnson_decoder_monitor (N=4, LOCK_CNT=3), with hold-allowed
// and hold-forbidden instances driven from the same stimulus.
module tb_johnson_decoder_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       se;
    logic [3:0] j;
    logic       clr;

    logic [2:0] a_idx,  b_idx;
    logic       a_vld,  b_vld;
    logic       a_ill,  b_ill;
    logic       a_seq,  b_seq;
    logic       a_wrap, b_wrap;
    logic       a_lck,  b_lck;
    logic [7:0] a_err,  b_err;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    johnson_decoder_monitor #(.N(4), .LOCK_CNT(3), .ALLOW_HOLD(1'b1)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_sample_en(se), .i_j_in(j), .i_clr_err(clr),
        .o_idx(a_idx), .o_idx_valid(a_vld), .o_illegal(a_ill), .o_seq_err(a_seq),
        .o_wrap(a_wrap), .o_locked(a_lck), .o_err_cnt(a_err)
    );

    johnson_decoder_monitor #(.N(4), .LOCK_CNT(3), .ALLOW_HOLD(1'b0)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_sample_en(se), .i_j_in(j), .i_clr_err(clr),
        .o_idx(b_idx), .o_idx_valid(b_vld), .o_illegal(b_ill), .o_seq_err(b_seq),
        .o_wrap(b_wrap), .o_locked(b_lck), .o_err_cnt(b_err)
    );

    typedef struct {
        logic       se;
        logic [3:0] j;
        logic [2:0] idx;
        logic       vld, ill, seq, wrap, lck;
        logic [7:0] err;
    } vec_t;

    vec_t tbl[29];

    function automatic vec_t mk(input logic s, input logic [3:0] jj, input logic [2:0] ix,
                                input logic v, input logic il, input logic sq,
                                input logic w, input logic l, input logic [7:0] e);
        vec_t r;
        r.se = s; r.j = jj; r.idx = ix; r.vld = v; r.ill = il; r.seq = sq;
        r.wrap = w; r.lck = l; r.err = e;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic apply(input logic s, input logic [3:0] jj, input logic c);
        se  = s;
        j   = jj;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, " idx"},  32'(a_idx),  0);
        chk({tag, " vld"},  32'(a_vld),  0);
        chk({tag, " ill"},  32'(a_ill),  0);
        chk({tag, " seq"},  32'(a_seq),  0);
        chk({tag, " wrap"}, 32'(a_wrap), 0);
        chk({tag, " lck"},  32'(a_lck),  0);
        chk({tag, " err"},  32'(a_err),  0);
    endtask

    initial begin
        //                se  j        idx   vld  ill  seq  wrap lck  err
        tbl[0]  = mk(1, 4'b0000, 3'd0, 1, 0, 0, 0, 0, 8'd0);
        tbl[1]  = mk(1, 4'b1000, 3'd1, 1, 0, 0, 0, 0, 8'd0);
        tbl[2]  = mk(1, 4'b1100, 3'd2, 1, 0, 0, 0, 0, 8'd0);
        tbl[3]  = mk(1, 4'b1110, 3'd3, 1, 0, 0, 0, 1, 8'd0);
        tbl[4]  = mk(1, 4'b1111, 3'd4, 1, 0, 0, 0, 1, 8'd0);
        tbl[5]  = mk(1, 4'b0111, 3'd5, 1, 0, 0, 0, 1, 8'd0);
        tbl[6]  = mk(1, 4'b0011, 3'd6, 1, 0, 0, 0, 1, 8'd0);
        tbl[7]  = mk(1, 4'b0001, 3'd7, 1, 0, 0, 0, 1, 8'd0);
        tbl[8]  = mk(1, 4'b0000, 3'd0, 1, 0, 0, 1, 1, 8'd0);
        tbl[9]  = mk(1, 4'b1000, 3'd1, 1, 0, 0, 0, 1, 8'd0);
        tbl[10] = mk(1, 4'b1100, 3'd2, 1, 0, 0, 0, 1, 8'd0);
        tbl[11] = mk(1, 4'b1010, 3'd2, 0, 1, 0, 0, 0, 8'd1);
        tbl[12] = mk(1, 4'b1110, 3'd3, 1, 0, 0, 0, 0, 8'd1);
        tbl[13] = mk(1, 4'b1111, 3'd4, 1, 0, 0, 0, 0, 8'd1);
        tbl[14] = mk(1, 4'b0111, 3'd5, 1, 0, 0, 0, 0, 8'd1);
        tbl[15] = mk(1, 4'b0011, 3'd6, 1, 0, 0, 0, 1, 8'd1);
        tbl[16] = mk(1, 4'b0001, 3'd7, 1, 0, 0, 0, 1, 8'd1);
        tbl[17] = mk(1, 4'b0000, 3'd0, 1, 0, 0, 1, 1, 8'd1);
        tbl[18] = mk(1, 4'b1000, 3'd1, 1, 0, 0, 0, 1, 8'd1);
        tbl[19] = mk(1, 4'b1100, 3'd2, 1, 0, 0, 0, 1, 8'd1);
        tbl[20] = mk(1, 4'b1110, 3'd3, 1, 0, 0, 0, 1, 8'd1);
        tbl[21] = mk(1, 4'b0111, 3'd5, 0, 0, 1, 0, 0, 8'd2);
        tbl[22] = mk(1, 4'b0011, 3'd6, 1, 0, 0, 0, 0, 8'd2);
        tbl[23] = mk(1, 4'b0001, 3'd7, 1, 0, 0, 0, 0, 8'd2);
        tbl[24] = mk(1, 4'b0000, 3'd0, 1, 0, 0, 1, 1, 8'd2);
        tbl[25] = mk(1, 4'b1000, 3'd1, 1, 0, 0, 0, 1, 8'd2);
        tbl[26] = mk(1, 4'b1100, 3'd2, 1, 0, 0, 0, 1, 8'd2);
        tbl[27] = mk(1, 4'b1110, 3'd3, 1, 0, 0, 0, 1, 8'd2);
        tbl[28] = mk(0, 4'b1010, 3'd3, 0, 0, 0, 0, 1, 8'd2);

        rst = 1'b1; se = 1'b0; j = 4'b0000; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_a_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 29; i++) begin
            apply(tbl[i].se, tbl[i].j, 1'b0);
            chk($sformatf("row%0d idx", i),  32'(a_idx),  32'(tbl[i].idx));
            chk($sformatf("row%0d vld", i),  32'(a_vld),  32'(tbl[i].vld));
            chk($sformatf("row%0d ill", i),  32'(a_ill),  32'(tbl[i].ill));
            chk($sformatf("row%0d seq", i),  32'(a_seq),  32'(tbl[i].seq));
            chk($sformatf("row%0d wrap", i), 32'(a_wrap), 32'(tbl[i].wrap));
            chk($sformatf("row%0d lck", i),  32'(a_lck),  32'(tbl[i].lck));
            chk($sformatf("row%0d err", i),  32'(a_err),  32'(tbl[i].err));
            chk($sformatf("row%0d b_lck", i), 32'(b_lck), 32'(tbl[i].lck));
            chk($sformatf("row%0d b_err", i), 32'(b_err), 32'(tbl[i].err));
        end

        // Repeat 1110: a hold on the permissive instance, a sequence error on the strict one.
        apply(1'b1, 4'b1110, 1'b0);
        chk("hold a vld", 32'(a_vld), 1);
        chk("hold a seq", 32'(a_seq), 0);
        chk("hold a lck", 32'(a_lck), 1);
        chk("hold a err", 32'(a_err), 2);
        chk("hold b vld", 32'(b_vld), 0);
        chk("hold b seq", 32'(b_seq), 1);
        chk("hold b idx", 32'(b_idx), 3);
        chk("hold b lck", 32'(b_lck), 0);
        chk("hold b err", 32'(b_err), 3);

        for (int i = 0; i < 300; i++) begin
            apply(1'b1, (i % 2 == 0) ? 4'b0101 : 4'b1010, 1'b0);
            if (i == 252) chk("sat a err at 255", 32'(a_err), 255);
        end
        chk("sat a err", 32'(a_err), 255);
        chk("sat b err", 32'(b_err), 255);
        chk("sat a ill", 32'(a_ill), 1);
        chk("sat a lck", 32'(a_lck), 0);

        apply(1'b1, 4'b0101, 1'b1);
        chk("clr+ill err", 32'(a_err), 1);
        chk("clr+ill ill", 32'(a_ill), 1);
        apply(1'b0, 4'b0000, 1'b1);
        chk("clr idle err", 32'(a_err), 0);
        apply(1'b1, 4'b1010, 1'b0);
        chk("ill err", 32'(a_err), 1);

        apply(1'b1, 4'b0000, 1'b0);
        apply(1'b1, 4'b1000, 1'b0);
        apply(1'b1, 4'b1100, 1'b0);
        apply(1'b1, 4'b1110, 1'b0);
        chk("relock idx", 32'(a_idx), 3);
        chk("relock lck", 32'(a_lck), 1);
        chk("relock err", 32'(a_err), 1);

        // Asynchronous reset between edges while locked with a live stream.
        #2;
        rst = 1'b1;
        #1;
        chk_a_zero("midreset");
        @(negedge clk);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/johnson_decoder_monitor.md
Name: johnson_decoder_monitor

Overview:
Receive-side companion to the team's Johnson (twisted-ring) counter. It samples an N-bit Johnson code and decodes it to a binary index 0..2N-1. It also checks that every legal code is the correct successor of the previous one and locks onto a valid stream. Illegal codes and sequence errors are flagged, and a saturating error count is kept. It sits downstream of any Johnson-counter bus, for example across a clock-domain or board boundary, as a decoder and integrity monitor.

Parameters:
N, 4, Johnson code width; N >= 2. Derived localparam IW = clog2(2N) (2 for N=2, 3 for N=4).
LOCK_CNT, 3, consecutive legal successors required to enter LOCKED; range 1..15.
ALLOW_HOLD, 1, 1: a repeated identical legal code is accepted as a hold; 0: a repeat is a sequence error.

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-high reset
SAMPLE_EN  input  1  sample J_IN on this rising edge
J_IN  input  N  Johnson code, bit N-1 = first stage (MSB-first fill)
CLR_ERR  input  1  synchronous clear of ERR_CNT
IDX  output  IW  decoded index of the last legal sample
IDX_VALID  output  1  1-cycle pulse: legal code decoded
ILLEGAL  output  1  1-cycle pulse: sampled code is not a Johnson state
SEQ_ERR  output  1  1-cycle pulse: legal code is not the expected successor while LOCKED
WRAP  output  1  1-cycle pulse: legal successor transition from 2N-1 to 0
LOCKED  output  1  level: stream verified
ERR_CNT  output  8  saturating count of ILLEGAL plus SEQ_ERR events

Behaviour:
- Reset (async, RESET=1):
  - All outputs go to 0.
  - FSM goes to UNLOCKED, the reference-valid flag clears, and good_cnt goes to 0.
  - Reset takes effect immediately, including mid-stream.
- Code sequence: 00..0 -> 10..0 -> 11..0 -> ... -> 11..1 -> 01..1 -> ... -> 00..1 -> 00..0.
- Legality: J_IN is legal iff the bit string J_IN[N-1:0] has at most one adjacent-bit transition. This gives exactly 2N legal codes.
- Decode:
  - If J_IN[0]=0, index = popcount(J_IN).
  - If J_IN[0]=1, index = N + (number of zero bits).
- Successor: the successor of index k is (k+1) mod 2N.
- Timing:
  - All outputs are registered and update on the SAMPLE_EN edge, giving 1-cycle latency.
  - With SAMPLE_EN=0: IDX, LOCKED and ERR_CNT hold, and all pulse outputs are 0.
- Per sample:
  - Illegal code:
    - ILLEGAL=1 and IDX holds.
    - ERR_CNT increments.
    - FSM goes to UNLOCKED; the reference flag and good_cnt clear.
  - Legal code:
    - IDX_VALID=1 and IDX = decoded index.
    - The reference stores the decoded index.
    - WRAP=1 if the code is a successor and the previous reference was 2N-1.
- FSM UNLOCKED:
  - No valid reference: store the reference, good_cnt=0.
  - Successor: good_cnt+1. When good_cnt reaches LOCK_CNT, LOCKED=1 on this same edge.
  - Hold with ALLOW_HOLD=1: good_cnt unchanged.
  - Any other legal code (including a hold with ALLOW_HOLD=0): good_cnt=0, reference = new index.
  - SEQ_ERR is never asserted in UNLOCKED.
- FSM LOCKED:
  - Successor, or hold with ALLOW_HOLD=1: stay LOCKED.
  - Any other legal code:
    - SEQ_ERR=1 and ERR_CNT increments.
    - FSM goes to UNLOCKED, good_cnt=0.
    - The reference becomes the new index, so reacquisition starts from it.
- ERR_CNT:
  - 8-bit, saturates at 255.
  - CLR_ERR clears it on any edge.
  - CLR_ERR and an error event on the same edge give ERR_CNT=1.
  - CLR_ERR is honoured regardless of SAMPLE_EN.
- ILLEGAL, SEQ_ERR and IDX_VALID are mutually exclusive.

Test Plan:
1. (N=4, LOCK_CNT=3) RESET, then 0000, 1000, 1100, 1110 with SAMPLE_EN=1 -> IDX 0,1,2,3, IDX_VALID each cycle. LOCKED rises with IDX=3. ERR_CNT=0.
2. While LOCKED, feed 1111, 0111, 0011, 0001, 0000 -> IDX 4,5,6,7,0. WRAP pulses exactly once, coincident with IDX=0. LOCKED stays 1.
3. While LOCKED at 1100 (IDX=2), feed 1010 -> ILLEGAL=1, IDX holds 2, ERR_CNT=1, LOCKED=0. Then 1110, 1111, 0111, 0011 -> relock on the 0011 sample.
4. While LOCKED at 1110 (IDX=3), feed 0111 (skip) -> SEQ_ERR=1, IDX=5, ERR_CNT+1, LOCKED=0. Then 0011, 0001, 0000 -> LOCKED=1 at IDX=0.
5. Hold check: ALLOW_HOLD=1, while LOCKED feed 1110 twice -> no error, 2 IDX_VALID pulses. Rebuild with ALLOW_HOLD=0, same stimulus -> SEQ_ERR on the repeat.
6. Feed 300 alternating illegal codes (0101, 1010) -> ERR_CNT saturates at 255. CLR_ERR together with an illegal sample -> ERR_CNT=1. RESET asserted between edges mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
